// File: rtl/gate_truth_sweeper.sv
// Closed-loop truth-table sweeper: drives every input combination into a
// combinational gate and waits SETTLE cycles per vector. It then samples the
// gate output and compares it against TRUTH. It reports the number of
// mismatches, the index of the first mismatch and a final pass flag.
module gate_truth_sweeper #(
  parameter int          N_IN   = 1,
  parameter logic [15:0] TRUTH  = 16'h0001,
  parameter int          SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] in_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_idx
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN:0]   ERR_ONE     = 1;
  localparam logic [N_IN-1:0] VEC_ONE     = 1;
  localparam logic [3:0]      CNT_ONE     = 1;

  state_t          state, state_nxt;
  logic [3:0]      settle_cnt, settle_cnt_nxt;
  logic [N_IN-1:0] in_vec_nxt, fail_idx_nxt;
  logic [N_IN:0]   err_count_nxt;
  logic            busy_nxt, done_nxt, pass_nxt;
  logic            mismatch;

  assign mismatch = (dut_out != TRUTH[in_vec]);

  // State and registered outputs; reset acts immediately, even mid-sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      in_vec     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_idx   <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      in_vec     <= in_vec_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_count_nxt;
      fail_idx   <= fail_idx_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless changed
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    in_vec_nxt     = in_vec;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    err_count_nxt  = err_count;
    fail_idx_nxt   = fail_idx;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          in_vec_nxt     = '0;
          settle_cnt_nxt = '0;
          err_count_nxt  = '0;
          fail_idx_nxt   = '0;
          pass_nxt       = 1'b0;
          done_nxt       = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = WAIT;
        end
      end
      WAIT: begin
        settle_cnt_nxt = settle_cnt + CNT_ONE;
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_count_nxt = err_count + ERR_ONE;
          if (err_count == '0) begin
            fail_idx_nxt = in_vec;
          end
        end
        if (&in_vec) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_count == '0) && !mismatch;
          state_nxt = DONE;
        end else begin
          in_vec_nxt     = in_vec + VEC_ONE;
          settle_cnt_nxt = '0;
          state_nxt      = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Scoreboard bench for gate_truth_sweeper. Three instances use different
// configurations: NOT, XOR2 checked against an AND2, and AND4. Stimulus
// pushes the expected end-of-sweep result, and a monitor pops it on each
// rising edge of done.
module tb_gate_truth_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    int inst;
    int cyc;
    int err;
    int fidx;
    int pass;
  } exp_t;
  exp_t q[$];

  // Instance 1: NOT gate, N_IN=1, SETTLE=2
  logic       start1 = 1'b0, stuck1 = 1'b0, d1;
  logic [0:0] v1, f1;
  logic [1:0] e1;
  logic       b1, dn1, p1;
  assign d1 = stuck1 ? 1'b0 : ~v1[0];

  // Instance 2: XOR2 table checked against an AND2 gate, SETTLE=1
  logic       start2 = 1'b0, d2;
  logic [1:0] v2, f2;
  logic [2:0] e2;
  logic       b2, dn2, p2;
  assign d2 = v2[0] & v2[1];

  // Instance 3: AND4, SETTLE=1, matching gate
  logic       start3 = 1'b0, d3;
  logic [3:0] v3, f3;
  logic [4:0] e3;
  logic       b3, dn3, p3;
  assign d3 = &v3;

  gate_truth_sweeper #(.N_IN(1), .TRUTH(16'h0001), .SETTLE(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(d1), .in_vec(v1),
    .busy(b1), .done(dn1), .pass(p1), .err_count(e1), .fail_idx(f1));

  gate_truth_sweeper #(.N_IN(2), .TRUTH(16'h0006), .SETTLE(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut_out(d2), .in_vec(v2),
    .busy(b2), .done(dn2), .pass(p2), .err_count(e2), .fail_idx(f2));

  gate_truth_sweeper #(.N_IN(4), .TRUTH(16'h8000), .SETTLE(1)) u3 (
    .clk(clk), .rst(rst), .start(start3), .dut_out(d3), .in_vec(v3),
    .busy(b3), .done(dn3), .pass(p3), .err_count(e3), .fail_idx(f3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a one-cycle start pulse; optionally queue the expected result
  task automatic pulse_start(input int inst, input bit push, input int lat,
                             input int err, input int fidx, input int pass);
    exp_t e;
    @(negedge clk);
    case (inst)
      1: start1 = 1'b1;
      2: start2 = 1'b1;
      default: start3 = 1'b1;
    endcase
    if (push) begin
      e.inst = inst; e.cyc = cyc + 1 + lat; e.err = err; e.fidx = fidx; e.pass = pass;
      q.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, q.size(), 0);
  endtask

  task automatic mon(input int inst, input int err, input int fidx,
                     input int pass, input int busy);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done: instance %0d raised done with nothing queued", inst);
    end else begin
      e = q.pop_front();
      chk("done_inst", inst, e.inst);
      chk("done_cycle", cyc, e.cyc);
      chk("err_count", err, e.err);
      chk("fail_idx", fidx, e.fidx);
      chk("pass", pass, e.pass);
      chk("busy_at_done", busy, 0);
    end
  endtask

  // Monitor: on each rising edge of done, compare against the scoreboard
  initial begin
    logic pd1, pd2, pd3;
    pd1 = 1'b0; pd2 = 1'b0; pd3 = 1'b0;
    forever begin
      @(negedge clk);
      if (dn1 && !pd1) mon(1, int'(e1), int'(f1), int'(p1), int'(b1));
      if (dn2 && !pd2) mon(2, int'(e2), int'(f2), int'(p2), int'(b2));
      if (dn3 && !pd3) mon(3, int'(e3), int'(f3), int'(p3), int'(b3));
      pd1 = dn1; pd2 = dn2; pd3 = dn3;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_vec", int'(v1), 0);
    chk("rst_busy", int'(b1), 0);
    chk("rst_done", int'(dn1), 0);
    chk("rst_pass", int'(p1), 0);
    chk("rst_err", int'(e1), 0);
    chk("rst_fidx", int'(f1), 0);
    chk("rst_busy4", int'(b3), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: NOT gate, correct; in_vec timing checked inline
    pulse_start(1, 1'b1, 6, 0, 0, 1);
    chk("t1_busy", int'(b1), 1);
    chk("t1_vec0", int'(v1), 0);
    chk("t1_done_low", int'(dn1), 0);
    repeat (2) @(negedge clk);
    chk("t1_vec0_hold", int'(v1), 0);
    @(negedge clk);
    chk("t1_vec1", int'(v1), 1);
    wait_drain("t1");

    // 2: output stuck at 0 -> vector 0 mismatches
    stuck1 = 1'b1;
    pulse_start(1, 1'b1, 6, 1, 0, 0);
    wait_drain("t2");
    stuck1 = 1'b0;

    // 3: XOR2 table vs AND2 gate -> vectors 1,2,3 mismatch
    pulse_start(2, 1'b1, 8, 3, 1, 0);
    wait_drain("t3");

    // 4: start while busy is ignored; start in DONE restarts
    pulse_start(1, 1'b1, 6, 0, 0, 1);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_drain("t4a");
    chk("t4_done_held", int'(dn1), 1);
    pulse_start(1, 1'b1, 6, 0, 0, 1);
    chk("t4_restart_done", int'(dn1), 0);
    chk("t4_restart_vec", int'(v1), 0);
    chk("t4_restart_busy", int'(b1), 1);
    wait_drain("t4b");

    // 5: async reset mid-sweep
    pulse_start(1, 1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("t5_vec_before", int'(v1), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_vec", int'(v1), 0);
    chk("t5_rst_busy", int'(b1), 0);
    chk("t5_rst_done", int'(dn1), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_idle_busy", int'(b1), 0);
    chk("t5_idle_vec", int'(v1), 0);
    chk("t5_idle_done", int'(dn1), 0);

    // 6: AND4, 16 vectors, matching gate
    pulse_start(3, 1'b1, 32, 0, 0, 1);
    wait_drain("t6");
    chk("t6_vec_last", int'(v3), 15);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_sweeper.md
Name: gate_truth_sweeper

Overview:
Self-checking stimulus and response stage for the logic-gate library. It drives every input combination into a combinational gate under test (NOT, AND, XOR, ...), waits a programmable settle time, then samples the gate output. It compares each sample against a parameterised truth table and reports the error count, the first failing index and a final pass/fail. It sits directly upstream of the gate (it drives the gate inputs) and directly downstream of it (it consumes the gate output), so gate benches can be closed-loop instead of monitor-only.

Parameters:
N_IN, 1, number of gate inputs swept; legal range 1..4.
TRUTH, 16'h0001, expected output table. Bit i is the expected out for in_vec == i. Only bits [2**N_IN-1:0] are used. NOT = 2'b01, AND2 = 4'b1000, XOR2 = 4'b0110.
SETTLE, 2, wait cycles per vector before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  sweep request, sampled on rising clk
dut_out  input  1  output of the gate under test
in_vec  output  N_IN  drive to gate inputs; bit 0 -> in1, bit 1 -> in2, ...
busy  output  1  high while a sweep runs
done  output  1  sticky high once a sweep completes
pass  output  1  valid when done; 1 = zero mismatches
err_count  output  N_IN+1  number of mismatching vectors in the last sweep
fail_idx  output  N_IN  index of the first mismatching vector; 0 if none

Behaviour:
- Reset (async, active-high): state=IDLE; in_vec, busy, done, pass, err_count, fail_idx and internal settle counter all 0. Takes effect immediately, including mid-sweep.
- States: IDLE, WAIT, CHECK, DONE. All outputs are registered.
- IDLE or DONE with start=1 at an edge:
  - in_vec<=0, settle_cnt<=0, err_count<=0, fail_idx<=0, pass<=0, done<=0, busy<=1.
  - Next state is WAIT.
- WAIT:
  - settle_cnt increments each edge.
  - When settle_cnt==SETTLE-1, go to CHECK.
  - WAIT lasts exactly SETTLE cycles; in_vec is stable throughout.
- CHECK (1 cycle): compare dut_out to TRUTH[in_vec].
  - Mismatch: err_count<=err_count+1. If this is the first mismatch of the sweep, fail_idx<=in_vec.
  - If in_vec==2**N_IN-1: busy<=0, done<=1, pass<=(final error count==0, including this vector), go to DONE. in_vec holds its last value.
  - Else: in_vec<=in_vec+1, settle_cnt<=0, go to WAIT.
- Latency: done rises exactly 2**N_IN*(SETTLE+1) cycles after the edge that sampled start.
- start while busy (WAIT/CHECK) is ignored; the sweep continues unaffected.
- DONE: done, pass, err_count and fail_idx hold until the next start or reset. A start in DONE clears done on the following edge and restarts from vector 0.
- err_count width N_IN+1 cannot overflow (maximum 2**N_IN). in_vec never wraps within a sweep.
- dut_out is sampled only in CHECK; its value in any other state has no effect.

Test Plan:
1. N_IN=1, TRUTH=2'b01, SETTLE=2, dut_out=~in_vec[0], pulse start -> in_vec=0 for 3 cycles, then 1 for 3 cycles; done=1 six cycles after start edge; pass=1, err_count=0, fail_idx=0.
2. Same config, dut_out stuck at 0 -> err_count=1, fail_idx=0, pass=0, done=1 at cycle 6.
3. N_IN=2, TRUTH=4'b0110, SETTLE=1, dut_out=in_vec[0]&in_vec[1] -> in_vec steps 0,1,2,3 every 2 cycles; done at cycle 8; err_count=3, fail_idx=1, pass=0.
4. Case 1 with start re-pulsed at cycle 3 (busy) -> no effect, done still at cycle 6. Then start pulsed in DONE -> done=0 next edge, in_vec=0, busy=1, second sweep completes with pass=1.
5. Case 1 with rst asserted asynchronously between edges at cycle 4 -> all outputs 0 before the next edge. After release, state stays IDLE and in_vec=0 until a new start.
6. N_IN=4, TRUTH=16'h8000 (AND4), SETTLE=1, matching model -> 16 vectors; done at cycle 32; pass=1, err_count=0.
